// File: rtl/mult_share_arb_pkg.sv
// rtl/mult_share_arb_pkg.sv - shared types, defaults and helpers for mult_share_arb
// Contents: slot_state_t (EMPTY/FULL), default NUM_REQ/WIDTH/CNT_W, idx_w().
package mult_share_arb_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_CNT_W   = 16;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mult_share_arb_pick.sv
// rtl/mult_share_arb_pick.sv - combinational requester picker for mult_share_arb
// Macro: MULT_SHARE_ARB_RR_EN selects round-robin from rr_ptr; otherwise lowest index wins.
// Ports: req_valid (in), rr_ptr (in, round-robin build only), enable (in),
//        grant (out, one-hot), grant_idx (out, encoded), grant_any (out).
module mult_share_arb_pick
    import mult_share_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
`ifdef MULT_SHARE_ARB_RR_EN
    input  logic [IDX_W-1:0]   rr_ptr,
`endif
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

`ifdef MULT_SHARE_ARB_RR_EN
    int               j;
    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate back towards rr_ptr so the last hit,
    // which is the closest to rr_ptr in wrap order, wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        idx       = '0;
        if (enable) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                idx = IDX_W'(j);
                if (req_valid[idx]) begin
                    grant_idx = idx;
                    grant_any = 1'b1;
                end
            end
        end
    end
`else
    // Descending scan: the lowest valid index is written last and wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        if (enable) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant_idx = IDX_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end
`endif

    assign grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - one shared WIDTH x WIDTH multiplier arbitrated among NUM_REQ requesters
// Macro: MULT_SHARE_ARB_RR_EN enables round-robin grant (rr_ptr); undefined gives fixed priority.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b per requester (packed);
//        rsp_valid/rsp_ready/rsp_id/rsp_p single-entry product slot; ops_done handshake counter.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  CNT_W   = DEF_CNT_W,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDX_W-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]         rsp_p,
    output logic [CNT_W-1:0]           ops_done
);

    slot_state_t        state;
    logic               slot_free;
    logic               rsp_hs;
    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] prod;

    assign rsp_valid = (state == FULL);
    assign rsp_hs    = rsp_valid & rsp_ready;
    // rst_n gates the picker so req_ready stays low for the whole reset window.
    assign slot_free = rst_n & ((state == EMPTY) | rsp_hs);

`ifdef MULT_SHARE_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
`endif

    mult_share_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
`ifdef MULT_SHARE_ARB_RR_EN
        .rr_ptr    (rr_ptr),
`endif
        .enable    (slot_free),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Operands are muxed and multiplied in the grant cycle; only the product is stored.
    assign op_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign op_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    assign prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            rsp_id   <= '0;
            rsp_p    <= '0;
            ops_done <= '0;
        end else begin
            if (grant_any) begin
                // Covers both EMPTY fill and same-cycle refill after a handshake.
                state  <= FULL;
                rsp_id <= grant_idx;
                rsp_p  <= prod;
            end else if (rsp_hs) begin
                state <= EMPTY;
            end
            if (rsp_hs) begin
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

`ifdef MULT_SHARE_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - self-checking bench for mult_share_arb against a reference model
module tb_mult_share_arb;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [2*W-1:0]  rsp_p;
    logic [CW-1:0]   ops_done;

    always #5 clk = ~clk;

    mult_share_arb #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .ops_done  (ops_done)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the slot contents, the completed-op count and the arbitration pointer.
    bit m_full;
    int m_id;
    int m_p;
    int m_ops;
    int m_ptr;

    logic [2*W-1:0] p_hold;
    logic [IW-1:0]  id_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_id   = 0;
        m_p    = 0;
        m_ops  = 0;
        m_ptr  = 0;
    endtask

    // Which requester should win among v; -1 when nobody is valid.
    function automatic int pick(input logic [N-1:0] v);
`ifdef MULT_SHARE_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic int opnd(input logic [N*W-1:0] bus, input int i);
        logic [W-1:0] f;
        f = bus[i*W +: W];
        return int'(f);
    endfunction

    // Entered at posedge+1 with inputs applied; checks at negedge, advances the model, returns at posedge+1.
    task automatic cycle(input string tag);
        int           g;
        logic [N-1:0] exp_rdy;
        bit           hs;
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            chk({tag, ".rsp_id"}, 32'(rsp_id), m_id);
            chk({tag, ".rsp_p"},  32'(rsp_p),  m_p);
        end
        chk({tag, ".ops_done"}, 32'(ops_done), m_ops);
        g = (!m_full || rsp_ready) ? pick(req_valid) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        hs = m_full && rsp_ready;
        if (hs) m_ops = (m_ops + 1) % (1 << CW);
        if (g >= 0) begin
            m_full = 1'b1;
            m_id   = g;
            m_p    = opnd(req_a, g) * opnd(req_b, g);
            m_ptr  = (g + 1) % N;
        end else if (hs) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        model_reset();

        // Reset with everybody requesting.
        repeat (3) @(posedge clk);
        #1;
        chk("reset.req_ready", 32'(req_ready), 0);
        chk("reset.rsp_valid", 32'(rsp_valid), 0);
        chk("reset.ops_done",  32'(ops_done),  0);
        chk("reset.rsp_p",     32'(rsp_p),     0);
        chk("reset.rsp_id",    32'(rsp_id),    0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        req_a = N*W'($urandom);
        req_b = N*W'($urandom);
        cycle("first");

        // Single operation from requester 1.
        req_valid = 4'b0010;
        set_op(1, 15, 15);
        cycle("single_issue");
        chk("single.rsp_valid", 32'(rsp_valid), 1);
        chk("single.rsp_p",     32'(rsp_p),     32'hE1);
        chk("single.rsp_id",    32'(rsp_id),    1);
        req_valid = '0;
        cycle("single_rsp");

        // Everybody valid, consumer always ready.
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            req_a = N*W'($urandom);
            req_b = N*W'($urandom);
            cycle("rr");
        end

        // Backpressure: slot full and consumer stalled.
        rsp_ready = 1'b0;
        cycle("bp_enter");
        p_hold  = rsp_p;
        id_hold = rsp_id;
        for (int i = 0; i < 5; i++) begin
            req_valid = N'($urandom);
            req_a     = N*W'($urandom);
            req_b     = N*W'($urandom);
            cycle("bp");
        end
        chk("bp.hold_p",  32'(rsp_p),  32'(p_hold));
        chk("bp.hold_id", 32'(rsp_id), 32'(id_hold));
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("bp.release_grant", 32'(req_ready), 32'h8);
        cycle("bp_release");

        // Reset while a product is pending.
        req_valid = '0;
        cycle("drain");
        req_valid = 4'b1000;
        set_op(3, 6, 6);
        cycle("pre_reset_issue");
        req_valid = '1;
        rsp_ready = 1'b0;
        chk("midreset.rsp_p", 32'(rsp_p), 32'h24);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.rsp_valid", 32'(rsp_valid), 0);
        chk("midreset.req_ready", 32'(req_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("after_reset.rsp_valid", 32'(rsp_valid), 0);
        chk("after_reset.ptr_zero",  32'(req_ready), 32'h1);

        // Counter wrap: 17 ops through requester 2 with a 4-bit counter.
        req_valid = 4'b0100;
        for (int i = 0; i < 17; i++) begin
            set_op(2, $urandom_range(0, 15), $urandom_range(0, 15));
            cycle("wrap");
        end
        req_valid = '0;
        cycle("wrap_drain");
        chk("wrap.ops_done", 32'(ops_done), 1);

        // Exhaustive operand sweep through requester 2.
        req_valid = 4'b0100;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_op(2, a, b);
                cycle("sweep");
            end
        end
        req_valid = '0;
        cycle("sweep_drain");

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            req_a     = N*W'($urandom);
            req_b     = N*W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
